ram_cmd_ctrl: RTL and testbench
===============================

Name: ram_cmd_ctrl

Overview:
- Command sequencer that sits directly upstream of the 4-bit register-file RAM (RAM4bit-style: shared data bus, address-demuxed gated write strobe, per-word parallel outputs).
- Accepts write, read and fill commands over a valid/ready interface.
- Drives a glitch-free, setup/hold-safe address/data/strobe sequence into the RAM, reads words back from the RAM's parallel outputs, and returns one response per command.

Parameters:
- DATA_W, 4, RAM word width.
- ADDR_W, 1, RAM address width; DEPTH = 2**ADDR_W words (default 2).
- STROBE_CYC, 1, number of cycles ram_we is held high per write (>=1).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  2  00 write, 01 read, 10 fill, 11 reserved.
- cmd_addr  input  ADDR_W  target word (write/read); ignored for fill.
- cmd_data  input  DATA_W  write data / fill seed.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes response.
- rsp_data  output  DATA_W  read data; 0 for write/fill/reserved.
- rsp_err  output  1  1 only for reserved op.
- ram_addr  output  ADDR_W  RAM address, registered.
- ram_d  output  DATA_W  RAM write data, registered.
- ram_we  output  1  RAM write strobe, registered (feeds the RAM's clock-gating demux).
- ram_q  input  DEPTH*DATA_W  RAM parallel outputs, word k at bits [k*DATA_W +: DATA_W].
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE. ram_we=0, ram_addr=0, ram_d=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. cmd_ready=1 after reset.
- cmd_ready = (state==IDLE) & ~rsp_valid, combinational from registers. A command is accepted on the edge where cmd_valid & cmd_ready. Cycle numbering below counts cycle 1 as the first cycle after the accept edge.
- States: IDLE, SETUP, STROBE, HOLD, CAPTURE, RESP.
- Write:
  - ram_addr and ram_d are loaded at the accept edge.
  - SETUP (cycle 1), then STROBE for STROBE_CYC cycles with ram_we=1, then HOLD (1 cycle, ram_we=0).
  - RESP follows with rsp_valid=1, rsp_data=0, rsp_err=0.
  - Default latency: ram_we high in cycle 2, rsp_valid from cycle 4.
- Read:
  - ram_addr is loaded at the accept edge.
  - SETUP (cycle 1), then CAPTURE (cycle 2). At the end of cycle 2, rsp_data is registered from the ram_q slice [ram_addr].
  - rsp_valid from cycle 3. ram_we stays 0.
- Fill:
  - Internal index i runs from 0 to DEPTH-1.
  - For each i: ram_addr=i, ram_d=(cmd_data+i) mod 2**DATA_W, then the SETUP/STROBE/HOLD sequence.
  - After the last HOLD, go to RESP with rsp_data=0, rsp_err=0.
  - Total: DEPTH*(2+STROBE_CYC) cycles, then rsp_valid.
- Reserved op (11): no RAM activity. Go directly to RESP with rsp_err=1, rsp_data=0; rsp_valid from cycle 1.
- RESP: rsp_valid, rsp_data and rsp_err are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid clears, state returns to IDLE, and cmd_ready rises the following cycle.
  - No back-to-back command accept in the handshake cycle.
- Strobe-safety invariants (the RAM gates its word clocks with ram_we):
  - ram_we is a direct flop output and never toggles combinationally.
  - ram_addr and ram_d change only on edges where ram_we is 0 both before and after the edge.
  - Every ram_we high interval is preceded by >=1 cycle (SETUP) and followed by >=1 cycle (HOLD) of stable ram_addr/ram_d.
- Arithmetic: the fill data sum is truncated to DATA_W (wrap-around, e.g. seed 4'hF, i=1 gives 4'h0). i wraps exactly at DEPTH-1, so the loop terminates.
- Reset mid-operation: ram_we drops asynchronously to 0, any in-flight command and response are discarded, and no response is produced for it.
- Inputs cmd_* are sampled only at accept. Changes while busy are ignored.
- rsp_ready is ignored outside RESP.

Test Plan:
- Reset, then write addr=1 data=4'hA with rsp_ready=1 -> ram_we=1 only in cycle 2 with ram_addr=1, ram_d=4'hA stable cycles 1-3. Response rsp_valid in cycle 4, rsp_data=0, rsp_err=0.
- Write addr=0 data=4'h5, then read addr=0 (with ram_q modelled by a behavioural RAM) -> read rsp_data=4'h5 at cycle 3 after accept, and ram_we never asserted during the read.
- Fill with seed 4'hF, DEPTH=2 -> word0=4'hF, word1=4'h0 (wrap). Exactly two ram_we pulses, rsp_valid after 6 cycles, cmd_ready low throughout.
- Reserved op 2'b11 -> rsp_err=1 and rsp_valid in cycle 1, no ram_we pulse. Then hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_err and rsp_data stay constant and cmd_ready stays 0.
- Assert rst_n=0 during STROBE of a write -> ram_we falls in the same cycle without waiting for clk, and all outputs return to reset values. After release, no rsp_valid appears and cmd_ready=1.
- STROBE_CYC=3 write, with a checker on every edge -> ram_we high exactly 3 consecutive cycles. ram_addr/ram_d never change adjacent to or during any ram_we high cycle.

Source files
------------

// File: rtl/ram_cmd_ctrl.sv
// Command sequencer for a small register-file RAM whose word clocks are gated by ram_we.
// Every write is framed as SETUP / STROBE / HOLD so address and data never move around a strobe.
module ram_cmd_ctrl #(
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [ADDR_W-1:0]                 cmd_addr,
    input  logic [DATA_W-1:0]                 cmd_data,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic                              rsp_err,
    output logic [ADDR_W-1:0]                 ram_addr,
    output logic [DATA_W-1:0]                 ram_d,
    output logic                              ram_we,
    input  logic [(2**ADDR_W)*DATA_W-1:0]     ram_q,
    output logic                              busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CAPTURE, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d, idx_nx;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                fill_q, fill_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_d_q, ram_d_d;
    logic                ram_we_q, ram_we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rd_word;

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < DEPTH; k++)
            if (ram_addr_q == ADDR_W'(k)) rd_word = ram_q[k*DATA_W +: DATA_W];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        seed_d      = seed_q;
        fill_d      = fill_q;
        rd_d        = rd_q;
        ram_addr_d  = ram_addr_q;
        ram_d_d     = ram_d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        idx_nx      = idx_q + ADDR_W'(1);
        unique case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                fill_d = 1'b0;
                rd_d   = 1'b0;
                unique case (cmd_op)
                    2'b00: begin
                        ram_addr_d = cmd_addr;
                        ram_d_d    = cmd_data;
                        state_d    = SETUP;
                    end
                    2'b01: begin
                        ram_addr_d = cmd_addr;
                        rd_d       = 1'b1;
                        state_d    = SETUP;
                    end
                    2'b10: begin
                        ram_addr_d = '0;
                        ram_d_d    = cmd_data;
                        seed_d     = cmd_data;
                        idx_d      = '0;
                        fill_d     = 1'b1;
                        state_d    = SETUP;
                    end
                    default: begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end
                endcase
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = rd_q ? CAPTURE : STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYC-1)) state_d = HOLD;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            HOLD: begin
                // Next fill word is loaded only here, where ram_we is low on both sides of the edge.
                if (fill_q && idx_q != ADDR_W'(DEPTH-1)) begin
                    idx_d      = idx_nx;
                    ram_addr_d = idx_nx;
                    ram_d_d    = seed_q + DATA_W'(idx_nx);
                    state_d    = SETUP;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end
            end
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_word;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Strobe is a pure flop of the next state so it cannot glitch into the RAM's gating.
        ram_we_d = (state_d == STROBE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            seed_q      <= '0;
            fill_q      <= 1'b0;
            rd_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
            ram_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            seed_q      <= seed_d;
            fill_q      <= fill_d;
            rd_q        <= rd_d;
            ram_addr_q  <= ram_addr_d;
            ram_d_q     <= ram_d_d;
            ram_we_q    <= ram_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign ram_we    = ram_we_q;
endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Scoreboard bench for ram_cmd_ctrl: one instance at STROBE_CYC=1, one at STROBE_CYC=3,
// each driving a behavioural 2x4 RAM.
module tb_ram_cmd_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, ram_we, busy;
    logic [1:0] cmd_op;
    logic       cmd_addr, ram_addr;
    logic [3:0] cmd_data, rsp_data, ram_d;
    logic [7:0] ram_q;
    logic [3:0] mem [2];

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3, ram_we3, busy3;
    logic [1:0] cmd_op3;
    logic       cmd_addr3, ram_addr3;
    logic [3:0] cmd_data3, rsp_data3, ram_d3;
    logic [7:0] ram_q3;
    logic [3:0] mem3 [2];

    ram_cmd_ctrl #(.DATA_W(4), .ADDR_W(1), .STROBE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
        .ram_q(ram_q), .busy(busy));

    ram_cmd_ctrl #(.DATA_W(4), .ADDR_W(1), .STROBE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3),
        .cmd_addr(cmd_addr3), .cmd_data(cmd_data3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_err(rsp_err3), .ram_addr(ram_addr3), .ram_d(ram_d3), .ram_we(ram_we3),
        .ram_q(ram_q3), .busy(busy3));

    always @(posedge clk) begin
        if (ram_we)  mem[ram_addr]   <= ram_d;
        if (ram_we3) mem3[ram_addr3] <= ram_d3;
    end
    assign ram_q  = {mem[1], mem[0]};
    assign ram_q3 = {mem3[1], mem3[0]};

    typedef struct packed { logic err; logic [3:0] data; } rsp_t;
    rsp_t       sb_q[$];
    logic [3:0] ref_mem [2];
    int n_cmp = 0, n_err = 0;

    // Address/data must not move on any edge adjacent to a strobe cycle.
    logic p_we, p_addr, p_rst, p_we3, p_addr3;
    logic [3:0] p_d, p_d3;
    int viol = 0, viol3 = 0, run3 = 0, runs3_n = 0, runs3_bad = 0;
    always @(negedge clk) begin
        if (rst_n && p_rst && (ram_we || p_we) && (ram_addr !== p_addr || ram_d !== p_d)) viol++;
        if (rst_n && p_rst && (ram_we3 || p_we3) && (ram_addr3 !== p_addr3 || ram_d3 !== p_d3)) viol3++;
        if (ram_we3) run3++;
        else if (run3 > 0) begin
            runs3_n++;
            if (run3 != 3) runs3_bad++;
            run3 = 0;
        end
        p_we = ram_we; p_addr = ram_addr; p_d = ram_d;
        p_we3 = ram_we3; p_addr3 = ram_addr3; p_d3 = ram_d3;
        p_rst = rst_n;
    end

    task automatic issue(input logic [1:0] op, input logic a, input logic [3:0] d, input rsp_t exp);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL issue_ready: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_addr = 1'($urandom); cmd_data = 4'($urandom);
    endtask

    task automatic collect(input string nm, input int exp_lat, input int chk_hi, input logic ea,
                           input logic [3:0] ed, output logic [31:0] we_mask);
        int lat = 0;
        bit rdy_bad = 0, stab_bad = 0;
        rsp_t e;
        we_mask = '0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if (ram_we === 1'b1) we_mask[c] = 1'b1;
            if (c <= chk_hi && (ram_addr !== ea || ram_d !== ed)) stab_bad = 1;
            if (cmd_ready !== 1'b0) rdy_bad = 1;
            if (rsp_valid === 1'b1) lat = c;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (lat != exp_lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
        n_cmp++;
        if ({rsp_err, rsp_data} !== e)
            begin n_err++; $display("FAIL %s rsp: got err=%b data=%h want err=%b data=%h", nm, rsp_err, rsp_data, e.err, e.data); end
        n_cmp++;
        if (rdy_bad) begin n_err++; $display("FAIL %s cmd_ready: got 1 while busy want 0", nm); end
        if (chk_hi > 0) begin
            n_cmp++;
            if (stab_bad) begin n_err++; $display("FAIL %s addr/data stability: want addr=%b data=%h held", nm, ea, ed); end
        end
        if (rsp_ready) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
                begin n_err++; $display("FAIL %s handshake: got valid=%b ready=%b want 0/1", nm, rsp_valid, cmd_ready); end
        end
    endtask

    task automatic test_reset;
        cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 1;
        cmd_valid3 = 0; cmd_op3 = 0; cmd_addr3 = 0; cmd_data3 = 0; rsp_ready3 = 1;
        #12;
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, ram_addr, ram_d, ram_we, busy} !== 14'b10000000000000)
            begin n_err++; $display("FAIL reset_hold: got rdy=%b v=%b we=%b busy=%b want 1/0/0/0", cmd_ready, rsp_valid, ram_we, busy); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, ram_addr, ram_d, ram_we, busy} !== 14'b10000000000000)
            begin n_err++; $display("FAIL reset_release: got rdy=%b v=%b we=%b busy=%b want 1/0/0/0", cmd_ready, rsp_valid, ram_we, busy); end
    endtask

    task automatic test_write;
        logic [31:0] m;
        issue(2'b00, 1'b1, 4'hA, '{err: 1'b0, data: 4'h0}); ref_mem[1] = 4'hA;
        collect("write", 4, 3, 1'b1, 4'hA, m);
        n_cmp++;
        if (m !== 32'h4) begin n_err++; $display("FAIL write_we_cycles: got %h want 00000004", m); end
        n_cmp++;
        if (mem[1] !== 4'hA) begin n_err++; $display("FAIL write_ram: got %h want a", mem[1]); end
    endtask

    task automatic test_read;
        logic [31:0] m;
        issue(2'b00, 1'b0, 4'h5, '{err: 1'b0, data: 4'h0}); ref_mem[0] = 4'h5;
        collect("write0", 4, 3, 1'b0, 4'h5, m);
        issue(2'b01, 1'b0, 4'h3, '{err: 1'b0, data: ref_mem[0]});
        collect("read0", 3, 0, 1'b0, 4'h0, m);
        n_cmp++;
        if (m !== 32'h0) begin n_err++; $display("FAIL read_no_we: got %h want 00000000", m); end
        issue(2'b01, 1'b1, 4'h0, '{err: 1'b0, data: ref_mem[1]});
        collect("read1", 3, 0, 1'b0, 4'h0, m);
    endtask

    task automatic test_fill;
        logic [31:0] m;
        issue(2'b10, 1'b0, 4'hF, '{err: 1'b0, data: 4'h0});
        ref_mem[0] = 4'hF; ref_mem[1] = 4'h0;
        collect("fill", 7, 0, 1'b0, 4'h0, m);
        n_cmp++;
        if (m !== 32'h24) begin n_err++; $display("FAIL fill_we_cycles: got %h want 00000024", m); end
        n_cmp++;
        if (mem[0] !== 4'hF || mem[1] !== 4'h0) begin n_err++; $display("FAIL fill_words: got %h %h want f 0", mem[0], mem[1]); end
        issue(2'b01, 1'b1, 4'h0, '{err: 1'b0, data: ref_mem[1]});
        collect("read_after_fill", 3, 0, 1'b0, 4'h0, m);
    endtask

    task automatic test_reserved;
        logic [31:0] m;
        bit bad = 0;
        rsp_ready = 1'b0;
        issue(2'b11, 1'b1, 4'h7, '{err: 1'b1, data: 4'h0});
        collect("reserved", 1, 0, 1'b0, 4'h0, m);
        n_cmp++;
        if (m !== 32'h0) begin n_err++; $display("FAIL reserved_no_we: got %h want 00000000", m); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 4'h0 || cmd_ready !== 1'b0 || ram_we !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL reserved_stall: got v=%b err=%b rdy=%b want 1/1/0 held", rsp_valid, rsp_err, cmd_ready); end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL reserved_release: got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] m;
        bit bad = 0;
        rsp_t dropped;
        issue(2'b00, 1'b0, 4'h7, '{err: 1'b0, data: 4'h0});
        dropped = sb_q.pop_back();
        @(posedge clk); #1;
        n_cmp++;
        if (ram_we !== 1'b1) begin n_err++; $display("FAIL mid_strobe: got we=%b want 1", ram_we); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, rsp_valid, rsp_data, rsp_err, ram_addr, ram_d, ram_we, busy} !== 14'b10000000000000)
            begin n_err++; $display("FAIL async_reset: got we=%b busy=%b addr=%b d=%h want 0/0/0/0", ram_we, busy, ram_addr, ram_d); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL post_reset: got v=%b rdy=%b want 0/1", rsp_valid, cmd_ready); end
        issue(2'b01, 1'b0, 4'h0, '{err: 1'b0, data: ref_mem[0]});
        collect("read_after_reset", 3, 0, 1'b0, 4'h0, m);
    endtask

    task automatic test_strobe3;
        int lat;
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            cmd_valid3 = 1'b1; cmd_op3 = (t == 0) ? 2'b00 : 2'b10; cmd_addr3 = 1'b1; cmd_data3 = (t == 0) ? 4'h9 : 4'hE;
            @(posedge clk); #1;
            cmd_valid3 = 1'b0; cmd_data3 = 4'($urandom);
            lat = 0;
            for (int c = 1; c <= 30 && lat == 0; c++) begin
                @(negedge clk);
                if (rsp_valid3 === 1'b1) lat = c;
            end
            n_cmp++;
            if (lat != ((t == 0) ? 6 : 11)) begin n_err++; $display("FAIL strobe3_latency[%0d]: got %0d want %0d", t, lat, (t == 0) ? 6 : 11); end
            n_cmp++;
            if ({rsp_err3, rsp_data3} !== 5'h0) begin n_err++; $display("FAIL strobe3_rsp[%0d]: got err=%b data=%h want 0/0", t, rsp_err3, rsp_data3); end
            @(negedge clk);
        end
        n_cmp++;
        if (mem3[0] !== 4'hE || mem3[1] !== 4'hF) begin n_err++; $display("FAIL strobe3_fill: got %h %h want e f", mem3[0], mem3[1]); end
        n_cmp++;
        if (runs3_n != 3 || runs3_bad != 0) begin n_err++; $display("FAIL strobe3_runs: got %0d runs %0d bad want 3/0", runs3_n, runs3_bad); end
        n_cmp++;
        if (viol3 != 0 || viol != 0) begin n_err++; $display("FAIL strobe_safety: got %0d/%0d violations want 0", viol, viol3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fill();
        test_reserved();
        test_reset_mid();
        test_strobe3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
